// File: rtl/demux_1to2_8b_buf.sv
// rtl/demux_1to2_8b_buf.sv - buffered 1-to-2 byte demultiplexer with per-path FIFOs

// Single-clock FIFO for one output path of the demultiplexer.
module demux_1to2_8b_buf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop_ready,
    output logic [WIDTH-1:0]           head_data,
    output logic                       head_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop;

    // A pop needs a non-empty FIFO; ready alone never moves anything.
    always_comb begin
        head_valid = (count != '0);
        pop        = head_valid && pop_ready;
        head_data  = mem[rd_ptr];
    end

    // Storage is cleared on reset so the heads read as zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// Top level: steers each input byte into FIFO A or B by in_sel.
module demux_1to2_8b_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_a_data,
    output logic                       out_a_valid,
    input  logic                       out_a_ready,
    output logic [WIDTH-1:0]           out_b_data,
    output logic                       out_b_valid,
    input  logic                       out_b_ready,
    output logic [$clog2(DEPTH):0]     a_count,
    output logic [$clog2(DEPTH):0]     b_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic push_a;
    logic push_b;

    // Ready depends only on the selected FIFO's registered count, never on
    // the consumers' ready, so a full destination stalls the input.
    always_comb begin
        in_ready = in_sel ? (b_count != FULL) : (a_count != FULL);
        push_a   = in_valid && in_ready && !in_sel;
        push_b   = in_valid && in_ready &&  in_sel;
    end

    demux_1to2_8b_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_a),
        .push_data  (in_data),
        .pop_ready  (out_a_ready),
        .head_data  (out_a_data),
        .head_valid (out_a_valid),
        .count      (a_count)
    );

    demux_1to2_8b_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_b),
        .push_data  (in_data),
        .pop_ready  (out_b_ready),
        .head_data  (out_b_data),
        .head_valid (out_b_valid),
        .count      (b_count)
    );

endmodule
